// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, bank state type and bit-reverse helper
package fft_pkg;
  localparam int FFT_DATA_WIDTH = 13;
  localparam int FFT_NUM = 16;
  localparam int FFT_NPT = 512;
  typedef enum logic {FREE, FULL} bank_state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r[5'(i)] = value[5'(nbits - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one frame buffer with NUM scattered writes and an aligned NUM-wide read
module fft_reorder_bank #(
  parameter int DATA_WIDTH = 13,
  parameter int NUM = 16,
  parameter int NPT = 512
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic        [$clog2(NPT)-1:0] waddr [0:NUM-1],
  input  logic signed [DATA_WIDTH-1:0] wdata_i [0:NUM-1],
  input  logic signed [DATA_WIDTH-1:0] wdata_q [0:NUM-1],
  input  logic [$clog2(NPT/NUM)-1:0]   raddr,
  output logic signed [DATA_WIDTH-1:0] rdata_i [0:NUM-1],
  output logic signed [DATA_WIDTH-1:0] rdata_q [0:NUM-1]
);
  localparam int LOG2_NUM = $clog2(NUM);
  logic signed [DATA_WIDTH-1:0] mem_i [NPT];
  logic signed [DATA_WIDTH-1:0] mem_q [NPT];
  // each lane lands at its own address; addresses within a beat never collide
  always_ff @(posedge clk)
    if (we)
      for (int l = 0; l < NUM; l++) begin
        mem_i[waddr[l]] <= wdata_i[l];
        mem_q[waddr[l]] <= wdata_q[l];
      end
  for (genvar g = 0; g < NUM; g++) begin : g_rd
    assign rdata_i[g] = mem_i[{raddr, LOG2_NUM'(g)}];
    assign rdata_q[g] = mem_q[{raddr, LOG2_NUM'(g)}];
  end
endmodule

// File: rtl/fft_reorder_pp.sv
// fft_reorder_pp: ping-pong bit-reverse to natural-order reorder with per-frame bypass
module fft_reorder_pp import fft_pkg::*; #(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int NUM = FFT_NUM,
  parameter int NPT = FFT_NPT
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         bypass,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic signed [DATA_WIDTH-1:0] din_i [0:NUM-1],
  input  logic signed [DATA_WIDTH-1:0] din_q [0:NUM-1],
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic signed [DATA_WIDTH-1:0] dout_i [0:NUM-1],
  output logic signed [DATA_WIDTH-1:0] dout_q [0:NUM-1],
  output logic                         dout_last
);
  localparam int LOG2_NPT = $clog2(NPT);
  localparam int BEATS = NPT / NUM;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LOG2_NUM = $clog2(NUM);
  bank_state_t st [2];
  logic byp [2];
  logic wsel, rsel, accept, load, wr_last, rd_last, cur_byp;
  logic [BEAT_W-1:0] wr_beat, rd_beat;
  logic [LOG2_NPT-1:0] waddr [0:NUM-1];
  logic signed [DATA_WIDTH-1:0] rd_i [2][0:NUM-1];
  logic signed [DATA_WIDTH-1:0] rd_q [2][0:NUM-1];
  assign ready_in = !rstn && st[wsel] == FREE;
  assign accept = valid_in && ready_in;
  assign wr_last = wr_beat == BEAT_W'(BEATS - 1);
  assign rd_last = rd_beat == BEAT_W'(BEATS - 1);
  assign cur_byp = wr_beat == '0 ? bypass : byp[wsel];
  assign load = st[rsel] == FULL && (!valid_out || ready_out);
  // banks always hold natural order, so the read side ignores the bypass bit
  for (genvar g = 0; g < NUM; g++) begin : g_wa
    logic [LOG2_NPT-1:0] k;
    assign k = {wr_beat, LOG2_NUM'(g)};
    assign waddr[g] = cur_byp ? k : LOG2_NPT'(bitrev(32'(k), LOG2_NPT));
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM(NUM), .NPT(NPT)) u_bank (
      .clk(clk), .we(accept && wsel == 1'(b)), .waddr(waddr),
      .wdata_i(din_i), .wdata_q(din_q), .raddr(rd_beat),
      .rdata_i(rd_i[b]), .rdata_q(rd_q[b])
    );
  end
  // bank ownership: writer fills wsel to FULL, reader drains rsel back to FREE
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      st[0] <= FREE;
      st[1] <= FREE;
      byp[0] <= 1'b0;
      byp[1] <= 1'b0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      wr_beat <= '0;
      rd_beat <= '0;
    end else begin
      if (accept) begin
        if (wr_beat == '0) byp[wsel] <= bypass;
        wr_beat <= wr_last ? '0 : wr_beat + 1'b1;
        if (wr_last) begin
          st[wsel] <= FULL;
          wsel <= ~wsel;
        end
      end
      if (load) rd_beat <= rd_last ? '0 : rd_beat + 1'b1;
      if (load && rd_last) begin
        st[rsel] <= FREE;
        rsel <= ~rsel;
      end
    end
  // output register: refill when empty or consumed, hold data under backpressure
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      valid_out <= 1'b0;
      dout_last <= 1'b0;
      for (int l = 0; l < NUM; l++) begin
        dout_i[l] <= '0;
        dout_q[l] <= '0;
      end
    end else if (load) begin
      valid_out <= 1'b1;
      dout_last <= rd_last;
      for (int l = 0; l < NUM; l++) begin
        dout_i[l] <= rd_i[rsel][l];
        dout_q[l] <= rd_q[rsel][l];
      end
    end else if (ready_out) begin
      valid_out <= 1'b0;
      dout_last <= 1'b0;
    end
endmodule

// File: tb/tb_fft_reorder_pp.sv
// tb_fft_reorder_pp: scoreboard and table checks for the ping-pong reorder stage
module tb_fft_reorder_pp;
  localparam int DW = 13;
  localparam int NUM = 16;
  localparam int NPT = 512;
  localparam int BEATS = NPT / NUM;
  localparam int LOG2 = 9;

  typedef struct {
    int tag;
    int beat;
    int lane;
    int ei;
    int eq;
    bit el;
  } vec_t;

  logic clk, rstn, bypass, valid_in, ready_in, valid_out, ready_out, dout_last;
  logic signed [DW-1:0] din_i [NUM];
  logic signed [DW-1:0] din_q [NUM];
  logic signed [DW-1:0] dout_i [NUM];
  logic signed [DW-1:0] dout_q [NUM];

  int n_cmp = 0, n_bad = 0, n_in = 0, n_out = 0, cyc = 0;
  int in_cnt = 0, out_pos = 0, t_last = 0, t_rise = 0;
  int stall_cnt = 0, run = 0, max_run = 0;
  bit fbyp, vo_prev, stream_en, m_bad, m_mis, rnd_done;
  int m_ei, m_eq;
  int fr_i [NPT];
  int fr_q [NPT];
  int exp_i [$];
  int exp_q [$];
  int log_i [$];
  int log_q [$];
  bit log_last [$];
  int base [3];
  vec_t tbl [12];

  fft_reorder_pp #(.DATA_WIDTH(DW), .NUM(NUM), .NPT(NPT)) dut (
    .clk(clk), .rstn(rstn), .bypass(bypass), .valid_in(valid_in), .ready_in(ready_in),
    .din_i(din_i), .din_q(din_q), .valid_out(valid_out), .ready_out(ready_out),
    .dout_i(dout_i), .dout_q(dout_q), .dout_last(dout_last)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rev(input int n);
    int r = 0;
    for (int i = 0; i < LOG2; i++) r = (r << 1) | ((n >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic flush();
    exp_i.delete();
    exp_q.delete();
    in_cnt = 0;
    out_pos = 0;
  endtask

  // one beat: offer it (valid with probability pv%) until the handshake happens
  task automatic send_beat(input int b, input bit byp, input bit rnd, input int pv);
    int g = 0;
    bit acc;
    bypass = b == 0 ? byp : ~byp;
    for (int l = 0; l < NUM; l++) begin
      din_i[l] = rnd ? DW'($urandom) : DW'(b * NUM + l);
      din_q[l] = rnd ? DW'($urandom) : DW'(-(b * NUM + l));
    end
    forever begin
      valid_in = $urandom_range(0, 99) < pv;
      @(negedge clk);
      acc = valid_in && ready_in;
      @(posedge clk);
      #1;
      if (acc) break;
      if (++g > 5000) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic send_frame(input bit byp, input bit rnd, input int pv, input int nb);
    for (int b = 0; b < nb; b++) send_beat(b, byp, rnd, pv);
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    while ((exp_i.size() != 0 || valid_out) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(nm, g < 3000, 1);
  endtask

  // reference model: collect frames on the input handshake, compare on the output handshake
  always @(negedge clk) begin
    if (!rstn && valid_in && ready_in) begin
      if (in_cnt == 0) fbyp = bypass;
      for (int l = 0; l < NUM; l++) begin
        fr_i[in_cnt * NUM + l] = int'(din_i[l]);
        fr_q[in_cnt * NUM + l] = int'(din_q[l]);
      end
      in_cnt++;
      n_in++;
      if (in_cnt == BEATS) begin
        for (int n = 0; n < NPT; n++) begin
          exp_i.push_back(fr_i[fbyp ? n : rev(n)]);
          exp_q.push_back(fr_q[fbyp ? n : rev(n)]);
        end
        in_cnt = 0;
        t_last = cyc;
      end
    end
    if (!rstn && valid_out && ready_out) begin
      n_cmp++;
      n_out++;
      if (exp_i.size() < NUM) begin
        n_bad++;
        $display("FAIL sb_extra: output beat %0d arrived with no sample pending", n_out);
      end else begin
        m_bad = 0;
        for (int l = 0; l < NUM; l++) begin
          m_ei = exp_i.pop_front();
          m_eq = exp_q.pop_front();
          log_i.push_back(int'(dout_i[l]));
          log_q.push_back(int'(dout_q[l]));
          m_mis = dout_i[l] !== m_ei || dout_q[l] !== m_eq;
          if (m_mis && !m_bad)
            $display("FAIL sb_data beat %0d lane %0d: got %0d/%0d expected %0d/%0d",
                     out_pos, l, dout_i[l], dout_q[l], m_ei, m_eq);
          if (m_mis) m_bad = 1;
        end
        log_last.push_back(dout_last);
        if (dout_last !== (out_pos == BEATS - 1)) begin
          $display("FAIL sb_last beat %0d: got %0b expected %0b", out_pos, dout_last, out_pos == BEATS - 1);
          m_bad = 1;
        end
        out_pos = (out_pos + 1) % BEATS;
        if (m_bad) n_bad++;
      end
    end
    if (stream_en && valid_in && !ready_in) stall_cnt++;
    run = valid_out && ready_out ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (valid_out && !vo_prev) t_rise = cyc;
    vo_prev = valid_out;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, nz, bi;
    tbl[0]  = '{0, 0, 0, 0, 0, 1'b0};
    tbl[1]  = '{0, 0, 1, 256, -256, 1'b0};
    tbl[2]  = '{0, 0, 2, 128, -128, 1'b0};
    tbl[3]  = '{0, 0, 3, 384, -384, 1'b0};
    tbl[4]  = '{0, 1, 1, 272, -272, 1'b0};
    tbl[5]  = '{0, 31, 15, 511, -511, 1'b1};
    tbl[6]  = '{1, 0, 0, 0, 0, 1'b0};
    tbl[7]  = '{1, 0, 5, 5, -5, 1'b0};
    tbl[8]  = '{1, 7, 3, 115, -115, 1'b0};
    tbl[9]  = '{1, 31, 15, 511, -511, 1'b1};
    tbl[10] = '{2, 0, 1, 256, -256, 1'b0};
    tbl[11] = '{2, 31, 15, 511, -511, 1'b1};
    rstn = 1;
    bypass = 0;
    valid_in = 0;
    ready_out = 1;
    stream_en = 0;
    for (int l = 0; l < NUM; l++) begin
      din_i[l] = '0;
      din_q[l] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_in", ready_in, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_dout0", dout_i[0], 0);
    rstn = 0;
    #1;
    chk("rel_ready_in", ready_in, 1);

    base[0] = log_last.size();
    send_frame(0, 0, 100, BEATS);
    valid_in = 0;
    wait_drain("reorder_drain");
    chk("latency", t_rise - t_last, 2);

    base[1] = log_last.size();
    send_frame(1, 0, 100, BEATS);
    valid_in = 0;
    wait_drain("bypass_drain");

    stall_cnt = 0;
    max_run = 0;
    stream_en = 1;
    repeat (4) send_frame(1'($urandom_range(0, 1)), 1, 100, BEATS);
    stream_en = 0;
    valid_in = 0;
    wait_drain("stream_drain");
    chk("stream_stalls", stall_cnt, 0);
    chk("stream_run", max_run, 4 * BEATS);

    ready_out = 0;
    bi = n_in;
    send_frame(0, 0, 100, BEATS);
    send_frame(0, 1, 100, BEATS);
    chk("bp_ready_in", ready_in, 0);
    chk("bp_accepted", n_in - bi, 2 * BEATS);
    chk("bp_valid", valid_out, 1);
    chk("bp_beat0_i", dout_i[1], 256);
    fork
      send_frame(1, 1, 100, BEATS);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("bp_still_blocked", ready_in, 0);
        chk("bp_no_extra", n_in - bi, 2 * BEATS);
        chk("bp_hold_i", dout_i[1], 256);
        chk("bp_hold_q", dout_q[1], -256);
        ready_out = 1;
      end
    join
    valid_in = 0;
    wait_drain("bp_drain");

    bi = n_in;
    idx = n_out;
    rnd_done = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) send_frame(1'($urandom_range(0, 1)), 1, 50, BEATS);
        valid_in = 0;
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk);
        #1;
        ready_out = 1'($urandom_range(0, 1));
      end
    join
    ready_out = 1;
    wait_drain("rand_drain");
    chk("rand_in_beats", n_in - bi, 20 * BEATS);
    chk("rand_out_beats", n_out - idx, 20 * BEATS);

    ready_out = 0;
    send_frame(0, 1, 100, BEATS);
    send_frame(0, 1, 100, 10);
    chk("pre_rst_valid", valid_out, 1);
    valid_in = 1;
    #2;
    rstn = 1;
    flush();
    #1;
    nz = 0;
    for (int l = 0; l < NUM; l++) if (dout_i[l] !== 0 || dout_q[l] !== 0) nz++;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_last", dout_last, 0);
    chk("mid_rst_zero_lanes", nz, 0);
    chk("mid_rst_ready_in", ready_in, 0);
    valid_in = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 0;
    #1;
    chk("post_rst_ready_in", ready_in, 1);
    ready_out = 1;
    base[2] = log_last.size();
    send_frame(0, 0, 100, BEATS);
    valid_in = 0;
    wait_drain("post_rst_drain");

    for (int v = 0; v < 12; v++) begin
      idx = base[tbl[v].tag] + tbl[v].beat;
      if (idx >= log_last.size()) chk($sformatf("vec%0d_missing", v), 0, 1);
      else begin
        chk($sformatf("vec%0d_i", v), log_i[idx * NUM + tbl[v].lane], tbl[v].ei);
        chk($sformatf("vec%0d_q", v), log_q[idx * NUM + tbl[v].lane], tbl[v].eq);
        chk($sformatf("vec%0d_last", v), 32'(log_last[idx]), 32'(tbl[v].el));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_reorder_pp.md
Name: fft_reorder_pp

Overview:
- Parametrised ping-pong reorder stage for the multi-lane FFT pipeline.
- Accepts one FFT frame of NPT complex samples, NUM lanes per beat, in bit-reversed order from the last butterfly stage.
- Emits the frame in natural order.
- Successor to the fixed 512-point/16-lane reorder:
  - generic point count, lane count and width;
  - ready/valid backpressure on both sides;
  - per-frame bypass mode;
  - frame-last marker.

Parameters:
- DATA_WIDTH, 13: signed width of each I/Q sample.
- NUM, 16: lanes per beat; power of 2, ≥2.
- NPT, 512: FFT points per frame; power of 2, ≥2*NUM.
- Derived localparams:
  - LOG2_NPT = $clog2(NPT).
  - BEATS = NPT/NUM.
  - BEAT_W = $clog2(BEATS).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  asynchronous reset, active-high (asserted = 1), clears all state immediately.
- bypass  input  1  sampled with beat 0 of each input frame: 1 = natural-order pass-through, 0 = bit-reverse reorder.
- valid_in  input  1  input beat valid.
- ready_in  output  1  block can accept an input beat.
- din_i  input  signed [DATA_WIDTH-1:0] x [0:NUM-1]  real lanes.
- din_q  input  signed [DATA_WIDTH-1:0] x [0:NUM-1]  imaginary lanes.
- valid_out  output  1  output beat valid.
- ready_out  input  1  downstream accepts beat.
- dout_i  output  signed [DATA_WIDTH-1:0] x [0:NUM-1]  real lanes, natural order.
- dout_q  output  signed [DATA_WIDTH-1:0] x [0:NUM-1]  imaginary lanes, natural order.
- dout_last  output  1  high on final beat (BEATS-1) of an output frame.

Behaviour:
- Reset (async, rstn=1):
  - valid_out=0, dout_last=0, dout_i/dout_q=0, ready_in=0 while asserted.
  - Both banks FREE; wsel=rsel=0; wr_beat=rd_beat=0.
  - Reset mid-frame discards all partial/pending frames.
  - After release, ready_in=1 in the first cycle.
- Storage: two banks (A/B), each NPT entries x {I,Q}. Per bank: state FREE/FULL plus latched bypass bit.
- Write side:
  - Accept when valid_in && ready_in; ready_in = (bank[wsel]==FREE).
  - Input position k = wr_beat*NUM + lane.
  - Store at address k if the frame's bypass=1, else at bitrev(k, LOG2_NPT).
  - bypass is latched into the bank on the beat with wr_beat==0; ignored on other beats.
  - On the accepted beat with wr_beat==BEATS-1: bank[wsel]<=FULL, wsel toggles, wr_beat<=0. Otherwise wr_beat increments.
- Read side:
  - Output register loads when bank[rsel]==FULL && (!valid_out || ready_out).
  - Load contents: entries rd_beat*NUM+lane, lane 0..NUM-1; valid_out<=1; dout_last<=(rd_beat==BEATS-1).
  - On loading the last beat: bank[rsel]<=FREE, rsel toggles, rd_beat<=0.
  - When valid_out && ready_out and nothing loads: valid_out<=0, dout_last<=0. Data holds its last value.
  - dout_i/dout_q stay stable while valid_out && !ready_out.
- Latency: beat 0 of a frame appears on valid_out 2 cycles after the cycle its last input beat is accepted.
- Throughput: with ready_out=1 and valid_in=1 continuously, frames stream with no bubbles on either side. Freeing a bank in cycle t allows write into it in cycle t+1.
- Simultaneous events:
  - A write completing on one bank and a read completing on the other in the same cycle are independent.
  - Same-bank conflict is impossible by construction.
- Backpressure: with both banks FULL, ready_in=0 until a bank drains. No data loss, no overwrite.
- No arithmetic: data is moved unmodified, no width change.

Decomposition:
- Shared package fft_pkg:
  - bitrev(value, nbits) function.
  - Typedef bank_state_t {FREE, FULL}.
  - Default DATA_WIDTH/NUM/NPT constants shared with the butterfly stages.
- Sub-module fft_reorder_bank:
  - One bank: NUM-port write with per-lane addresses, NUM-wide aligned read.
  - Instantiated twice.
- Top holds the bank state machine, counters and output register.

Test Plan:
- Reorder, NPT=512, NUM=16, bypass=0: input din_i at position k = k, din_q = -k. First output beat lanes 0..3: dout_i = 0, 256, 128, 384, dout_q negated. Beat 31 lane 15 (n=511): 511, dout_last=1. valid_out rises exactly 2 cycles after input beat 31.
- Bypass: same stimulus with bypass=1 on beat 0 (toggled to 0 mid-frame). Output equals input order (beat b lane l = b*16+l). Bypass change mid-frame has no effect.
- Streaming: 4 back-to-back frames, valid_in=1, ready_out=1. ready_in never drops after reset; 128 consecutive valid_out beats; dout_last every 32nd beat.
- Backpressure: ready_out=0 while 3 frames are offered. ready_in falls after 64 accepted beats. Output beat 0 held stable. Release ready_out: all 3 frames emerge intact and in order.
- Random ready_out/valid_in (50%) over 20 frames vs. scoreboard model: zero mismatches, no lost or duplicated beats.
- Reset mid-frame: assert rstn during input beat 10 of frame 2 with frame 1 pending. valid_out drops immediately, outputs read 0. After release, a fresh frame reorders correctly with no residue.
